// File: rtl/mem_req_sched_pkg.sv
// mem_req_sched_pkg: shared encodings for the memory request scheduler.
// Revision 1.0
`default_nettype none

package mem_req_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DROP  = 2'd3
  } state_t;

  typedef enum logic {
    SRC_IF = 1'b0,
    SRC_LS = 1'b1
  } src_t;

  localparam logic [2:0]  LEN_1       = 3'd1;
  localparam logic [2:0]  LEN_2       = 3'd2;
  localparam logic [2:0]  LEN_4       = 3'd4;
  localparam logic [31:0] DEF_IO_BASE = 32'h0003_0000;

  // Any byte count other than 1 or 2 is issued as a full word.
  function automatic logic [2:0] norm_len(input logic [2:0] len);
    case (len)
      LEN_1:   return LEN_1;
      LEN_2:   return LEN_2;
      default: return LEN_4;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection between fetch and load/store.
// Revision 1.0
`default_nettype none

module mem_arb_pick
  import mem_req_sched_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                CNT_W      = 3,
  parameter int                STARVE_MAX = 4,
  parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'(DEF_IO_BASE)
) (
  input  logic              if_req,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic              io_buffer_full,
  input  logic [CNT_W-1:0]  starve_cnt,
  output logic              pick_if,
  output logic              pick_ls
);

  logic ls_io_blocked;
  logic if_starved;

  always_comb begin
    ls_io_blocked = ls_we && (ls_addr >= IO_BASE) && io_buffer_full;
    if_starved    = if_req && (starve_cnt == CNT_W'(STARVE_MAX));
    pick_ls       = ls_req && !ls_io_blocked && !if_starved;
    pick_if       = if_req && !pick_ls;
  end

endmodule

`default_nettype wire

// File: rtl/mem_req_sched.sv
// mem_req_sched: arbitrates fetch and load/store onto the byte-serial memory controller.
// Revision 1.0
`default_nettype none

module mem_req_sched
  import mem_req_sched_pkg::*;
#(
  parameter int                ADDR_W     = 32,
  parameter int                DATA_W     = 32,
  parameter int                STARVE_MAX = 4,
  parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'(DEF_IO_BASE)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              clr,
  input  logic              io_buffer_full,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_grant,
  output logic              if_done,
  output logic [DATA_W-1:0] if_inst,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [2:0]        ls_len,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_grant,
  output logic              ls_done,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              m_valid,
  output logic              m_we,
  output logic [2:0]        m_len,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_ready,
  input  logic              m_done,
  input  logic [DATA_W-1:0] m_rdata
);

  localparam int CNT_W  = $clog2(STARVE_MAX + 1);
  localparam int NBYTES = DATA_W / 8;

  state_t            state, state_nx;
  src_t              src, src_nx;
  logic              drop_pend, drop_pend_nx;
  logic [CNT_W-1:0]  starve_cnt, starve_cnt_nx;
  logic              m_valid_nx, m_we_nx;
  logic [2:0]        m_len_nx;
  logic [ADDR_W-1:0] m_addr_nx;
  logic [DATA_W-1:0] m_wdata_nx;
  logic              if_done_nx, ls_done_nx;
  logic [DATA_W-1:0] if_inst_nx, ls_rdata_nx;
  logic              pick_if, pick_ls;
  logic              arb_en, is_store, cancel;
  logic [DATA_W-1:0] load_data;

  mem_arb_pick #(
    .ADDR_W     (ADDR_W),
    .CNT_W      (CNT_W),
    .STARVE_MAX (STARVE_MAX),
    .IO_BASE    (IO_BASE)
  ) u_pick (
    .if_req         (if_req),
    .ls_req         (ls_req),
    .ls_we          (ls_we),
    .ls_addr        (ls_addr),
    .io_buffer_full (io_buffer_full),
    .starve_cnt     (starve_cnt),
    .pick_if        (pick_if),
    .pick_ls        (pick_ls)
  );

  // No arbitration while a done pulse is still being presented.
  assign arb_en   = rdy && !rst && !clr && (state == ST_IDLE) && !if_done && !ls_done;
  assign if_grant = arb_en && pick_if;
  assign ls_grant = arb_en && pick_ls;
  assign is_store = (src == SRC_LS) && m_we;
  assign cancel   = clr && !is_store;

  always_comb begin
    load_data = '0;
    for (int b = 0; b < NBYTES; b++) begin
      if (b < int'(m_len)) load_data[b*8 +: 8] = m_rdata[b*8 +: 8];
    end
  end

  always_comb begin
    state_nx      = state;
    src_nx        = src;
    drop_pend_nx  = drop_pend;
    starve_cnt_nx = starve_cnt;
    m_valid_nx    = m_valid;
    m_we_nx       = m_we;
    m_len_nx      = m_len;
    m_addr_nx     = m_addr;
    m_wdata_nx    = m_wdata;
    if_done_nx    = 1'b0;
    ls_done_nx    = 1'b0;
    if_inst_nx    = if_inst;
    ls_rdata_nx   = ls_rdata;

    if (!if_req || if_grant)
      starve_cnt_nx = '0;
    else if (ls_grant && (starve_cnt != CNT_W'(STARVE_MAX)))
      starve_cnt_nx = starve_cnt + CNT_W'(1);

    case (state)
      ST_IDLE: begin
        drop_pend_nx = 1'b0;
        if (if_grant) begin
          src_nx     = SRC_IF;
          m_valid_nx = 1'b1;
          m_we_nx    = 1'b0;
          m_len_nx   = LEN_4;
          m_addr_nx  = if_addr;
          m_wdata_nx = '0;
          state_nx   = ST_ISSUE;
        end else if (ls_grant) begin
          src_nx     = SRC_LS;
          m_valid_nx = 1'b1;
          m_we_nx    = ls_we;
          m_len_nx   = norm_len(ls_len);
          m_addr_nx  = ls_addr;
          m_wdata_nx = ls_wdata;
          state_nx   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        // A flush mid-handshake still completes the handshake, then discards.
        if (m_ready) begin
          m_valid_nx   = 1'b0;
          drop_pend_nx = 1'b0;
          state_nx     = (cancel || drop_pend) ? ST_DROP : ST_WAIT;
        end else if (cancel) begin
          drop_pend_nx = 1'b1;
        end
      end
      ST_WAIT: begin
        if (m_done) begin
          state_nx = ST_IDLE;
          if (!cancel) begin
            if (src == SRC_IF) begin
              if_done_nx = 1'b1;
              if_inst_nx = m_rdata;
            end else begin
              ls_done_nx  = 1'b1;
              ls_rdata_nx = m_we ? '0 : load_data;
            end
          end
        end else if (cancel) begin
          state_nx = ST_DROP;
        end
      end
      ST_DROP: begin
        if (m_done) state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      src        <= SRC_IF;
      drop_pend  <= 1'b0;
      starve_cnt <= '0;
      m_valid    <= 1'b0;
      m_we       <= 1'b0;
      m_len      <= '0;
      m_addr     <= '0;
      m_wdata    <= '0;
      if_done    <= 1'b0;
      ls_done    <= 1'b0;
      if_inst    <= '0;
      ls_rdata   <= '0;
    end else if (rdy) begin
      state      <= state_nx;
      src        <= src_nx;
      drop_pend  <= drop_pend_nx;
      starve_cnt <= starve_cnt_nx;
      m_valid    <= m_valid_nx;
      m_we       <= m_we_nx;
      m_len      <= m_len_nx;
      m_addr     <= m_addr_nx;
      m_wdata    <= m_wdata_nx;
      if_done    <= if_done_nx;
      ls_done    <= ls_done_nx;
      if_inst    <= if_inst_nx;
      ls_rdata   <= ls_rdata_nx;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_req_sched.sv
// tb_mem_req_sched: directed and randomized checks of mem_req_sched against a rule-level model.
// Revision 1.0
`timescale 1ns/1ps
`default_nettype none

module tb_mem_req_sched;

  localparam int          ADDR_W     = 32;
  localparam int          DATA_W     = 32;
  localparam int          STARVE_MAX = 4;
  localparam logic [31:0] IO_BASE    = 32'h0003_0000;

  logic              clk = 1'b0;
  logic              rst, rdy, clr, io_buffer_full;
  logic              if_req, ls_req, ls_we, m_ready, m_done;
  logic [ADDR_W-1:0] if_addr, ls_addr;
  logic [2:0]        ls_len;
  logic [DATA_W-1:0] ls_wdata, m_rdata;
  logic              if_grant, if_done, ls_grant, ls_done, m_valid, m_we;
  logic [DATA_W-1:0] if_inst, ls_rdata, m_wdata;
  logic [2:0]        m_len;
  logic [ADDR_W-1:0] m_addr;

  int n_cmp  = 0;
  int n_fail = 0;
  int ls_since_if = 0;

  always #5 clk = ~clk;

  mem_req_sched #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(STARVE_MAX), .IO_BASE(IO_BASE)
  ) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .clr(clr), .io_buffer_full(io_buffer_full),
    .if_req(if_req), .if_addr(if_addr), .if_grant(if_grant), .if_done(if_done), .if_inst(if_inst),
    .ls_req(ls_req), .ls_we(ls_we), .ls_len(ls_len), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_grant(ls_grant), .ls_done(ls_done), .ls_rdata(ls_rdata),
    .m_valid(m_valid), .m_we(m_we), .m_len(m_len), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_done(m_done), .m_rdata(m_rdata)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  // Rule-level winner: 0 none, 1 fetch, 2 load/store.
  function automatic int exp_winner();
    bit ls_ok;
    ls_ok = ls_req && !(ls_we && (ls_addr >= IO_BASE) && io_buffer_full);
    if (ls_ok && !(if_req && ls_since_if >= STARVE_MAX)) return 2;
    if (if_req) return 1;
    return 0;
  endfunction

  function automatic logic [31:0] zext_bytes(input logic [31:0] d, input int n);
    case (n)
      1:       return {24'h0, d[7:0]};
      2:       return {16'h0, d[15:0]};
      default: return d;
    endcase
  endfunction

  // Waits for a grant, plays the controller, and checks the completion.
  task automatic txn(output int w, input logic [31:0] rdata, input int rdly, input int ddly,
                     input int clr_mode, input bit hold_rdy);
    int                exp_w;
    int                budget;
    logic [ADDR_W-1:0] ea;
    int                el;
    logic              ewe;
    logic [DATA_W-1:0] ewd;
    bit                dropped;
    budget = 0;
    sample();
    while (!(if_grant || ls_grant) && budget < 20) begin
      next_cycle();
      sample();
      budget++;
    end
    exp_w = exp_winner();
    w = if_grant ? 1 : (ls_grant ? 2 : 0);
    chk("grant_src", w, exp_w);
    chk("grant_onehot", if_grant && ls_grant, 0);
    if (w == 0) return;
    if (w == 1) begin
      ea = if_addr; el = 4; ewe = 1'b0; ewd = '0;
      ls_since_if = 0;
    end else begin
      ea = ls_addr; el = (ls_len == 3'd3) ? 4 : int'(ls_len); ewe = ls_we; ewd = ls_wdata;
      ls_since_if = if_req ? ls_since_if + 1 : 0;
    end
    next_cycle();
    if (w == 1) if_req = 1'b0; else ls_req = 1'b0;
    sample();
    chk("m_valid_up", m_valid, 1);
    chk("m_addr", m_addr, ea);
    chk("m_len", m_len, el);
    chk("m_we", m_we, ewe);
    if (ewe) chk("m_wdata", m_wdata, ewd);
    chk("no_grant_busy", if_grant || ls_grant, 0);
    for (int i = 0; i < rdly; i++) begin
      next_cycle();
      sample();
      chk("m_stable", {m_valid, m_addr}, {1'b1, ea});
    end
    next_cycle();
    m_ready = 1'b1;
    sample();
    chk("m_valid_hs", m_valid, 1);
    next_cycle();
    m_ready = 1'b0;
    if (clr_mode == 1) clr = 1'b1;
    sample();
    chk("m_valid_down", m_valid, 0);
    for (int i = 0; i < ddly; i++) begin
      next_cycle();
      clr = 1'b0;
      sample();
    end
    next_cycle();
    clr     = (clr_mode == 2);
    m_done  = 1'b1;
    m_rdata = rdata;
    sample();
    chk("done_not_early", if_done || ls_done, 0);
    next_cycle();
    m_done  = 1'b0;
    clr     = 1'b0;
    m_rdata = $urandom;
    sample();
    dropped = (clr_mode != 0) && !(w == 2 && ewe);
    chk("if_done", if_done, (w == 1) && !dropped);
    chk("ls_done", ls_done, (w == 2) && !dropped);
    if (w == 1 && !dropped) chk("if_inst", if_inst, rdata);
    if (w == 2 && !dropped) chk("ls_rdata", ls_rdata, ewe ? 32'h0 : zext_bytes(rdata, el));
    if (!dropped) chk("no_grant_done_cycle", if_grant || ls_grant, 0);
    if (hold_rdy) begin
      rdy = 1'b0;
      for (int i = 0; i < 3; i++) begin
        next_cycle();
        sample();
        chk("rdy_hold_done", {if_done, ls_done}, {w == 1, w == 2});
      end
      rdy = 1'b1;
    end
  endtask

  initial begin
    int w;
    int ls_issued;
    int order[6];
    order = '{2, 2, 2, 2, 1, 2};
    rst = 1'b1; rdy = 1'b1; clr = 1'b0; io_buffer_full = 1'b0;
    if_req = 1'b0; if_addr = '0; ls_req = 1'b0; ls_we = 1'b0; ls_len = 3'd4;
    ls_addr = '0; ls_wdata = '0; m_ready = 1'b0; m_done = 1'b0; m_rdata = '0;
    repeat (3) next_cycle();
    sample();
    chk("rst_ctl", {if_grant, if_done, ls_grant, ls_done, m_valid, m_we, m_len}, 0);
    chk("rst_data", {if_inst, ls_rdata}, 0);
    chk("rst_maddr", {m_addr, m_wdata}, 0);
    next_cycle();
    rst = 1'b0;

    // Fetch alone.
    if_req = 1'b1; if_addr = 32'h100;
    txn(w, 32'h00c00093, 0, 0, 0, 0);
    chk("tp1_src", w, 1);
    chk("tp1_starve", dut.starve_cnt, 0);
    next_cycle();

    // Fetch and load together: load first.
    if_req = 1'b1; if_addr = 32'h104;
    ls_req = 1'b1; ls_we = 1'b0; ls_len = 3'd2; ls_addr = 32'h200;
    txn(w, 32'hdeadbeef, 1, 1, 0, 0);
    chk("tp2_first", w, 2);
    chk("tp2_rdata", ls_rdata, 32'h0000beef);
    next_cycle();
    txn(w, $urandom, 0, 0, 0, 0);
    chk("tp2_second", w, 1);
    next_cycle();

    // Fetch starved by back-to-back loads.
    if_req = 1'b1; if_addr = 32'h108;
    ls_req = 1'b1; ls_we = 1'b0; ls_len = 3'd4; ls_addr = 32'h300;
    ls_issued = 1;
    for (int k = 0; k < 6; k++) begin
      txn(w, $urandom, 0, 0, 0, 0);
      chk("starve_order", w, order[k]);
      next_cycle();
      if (ls_issued < 5 && !ls_req) begin
        ls_req = 1'b1; ls_we = 1'b0; ls_len = 3'd4; ls_addr = 32'h300 + 32'(4 * ls_issued);
        ls_issued++;
      end
    end

    // IO store blocked while the IO buffer is full.
    io_buffer_full = 1'b1;
    ls_req = 1'b1; ls_we = 1'b1; ls_len = 3'd4; ls_addr = 32'h30000; ls_wdata = 32'hcafef00d;
    if_req = 1'b1; if_addr = 32'h10c;
    txn(w, $urandom, 0, 0, 0, 0);
    chk("io_if_first", w, 1);
    next_cycle();
    for (int i = 0; i < 3; i++) begin
      sample();
      chk("io_store_held", ls_grant, 0);
      next_cycle();
    end
    io_buffer_full = 1'b0;
    txn(w, $urandom, 0, 0, 0, 0);
    chk("io_store_go", w, 2);
    next_cycle();

    // Flush: in IDLE, in WAIT for fetch and store, coincident with done for a load.
    if_req = 1'b1; if_addr = 32'h110; clr = 1'b1;
    sample();
    chk("clr_idle_nogrant", if_grant, 0);
    next_cycle();
    clr = 1'b0;
    txn(w, $urandom, 0, 2, 1, 0);
    chk("clr_if_src", w, 1);
    next_cycle();
    ls_req = 1'b1; ls_we = 1'b1; ls_len = 3'd4; ls_addr = 32'h400; ls_wdata = 32'h11223344;
    txn(w, $urandom, 0, 2, 1, 0);
    chk("clr_st_src", w, 2);
    next_cycle();
    ls_req = 1'b1; ls_we = 1'b0; ls_len = 3'd1; ls_addr = 32'h404;
    txn(w, $urandom, 1, 1, 2, 0);
    next_cycle();

    // rdy=0 holds a done pulse.
    if_req = 1'b1; if_addr = 32'h600;
    txn(w, 32'h12345678, 1, 1, 0, 1);
    next_cycle();

    // rdy=0 freezes ISSUE, then rst mid-transaction.
    if_req = 1'b1; if_addr = 32'h500;
    sample();
    chk("rst_tc_grant", if_grant, 1);
    ls_since_if = 0;
    next_cycle();
    if_req = 1'b0;
    sample();
    chk("rst_tc_issue", m_valid, 1);
    next_cycle();
    rdy = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      sample();
      chk("rdy_hold_issue", {m_valid, m_addr}, {1'b1, 32'h500});
    end
    rdy = 1'b1; m_ready = 1'b0; rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    sample();
    chk("rst_mid_ctl", {if_grant, if_done, ls_grant, ls_done, m_valid, m_we, m_len}, 0);
    chk("rst_mid_data", {if_inst, ls_rdata}, 0);
    chk("rst_mid_maddr", {m_addr, m_wdata}, 0);
    ls_since_if = 0;
    next_cycle();

    // Randomized traffic against the rule model.
    for (int r = 0; r < 40; r++) begin
      if (!if_req && $urandom_range(0, 1) == 1) begin
        if_req = 1'b1; if_addr = $urandom & 32'hffff_fffc;
      end
      if (!ls_req && $urandom_range(0, 2) != 0) begin
        ls_req   = 1'b1;
        ls_we    = 1'($urandom_range(0, 1));
        ls_len   = 3'($urandom_range(1, 4));
        ls_addr  = ($urandom_range(0, 1) == 1) ? IO_BASE + 32'($urandom_range(0, 255))
                                                : 32'($urandom_range(0, 16'hffff));
        ls_wdata = $urandom;
      end
      io_buffer_full = ($urandom_range(0, 3) == 0);
      if (!if_req && !ls_req) begin
        if_req = 1'b1; if_addr = $urandom & 32'hffff_fffc;
      end
      if (!if_req && ls_we && ls_addr >= IO_BASE) io_buffer_full = 1'b0;
      txn(w, $urandom, $urandom_range(0, 2), $urandom_range(0, 2), 0, 0);
      next_cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/mem_req_sched.md
# mem_req_sched

Request scheduler in front of the byte-serial memory controller. It arbitrates between instruction fetch and the load/store unit, presents one request at a time to the controller, and routes the completion back to its owner. It also enforces IO-store back-pressure and an anti-starvation rule for fetch, and drops speculative results on pipeline flush.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data/instruction width
- `STARVE_MAX`, 4, consecutive LS grants allowed while IF waits
- `IO_BASE`, 32'h30000, addresses ≥ this are IO

Ports:
- `clk`  in  1  clock
- `rst`  in  1  reset; synchronous, active-high
- `rdy`  in  1  global enable; 0 freezes all state and outputs
- `clr`  in  1  pipeline flush (branch mispredict)
- `io_buffer_full`  in  1  IO output buffer full
- `if_req`  in  1  fetch request, held until `if_grant`
- `if_addr`  in  ADDR_W  fetch address
- `if_grant`  out  1  one-cycle pulse: fetch request accepted
- `if_done`  out  1  one-cycle pulse: `if_inst` valid
- `if_inst`  out  DATA_W  fetched word
- `ls_req`  in  1  LS request, held until `ls_grant`
- `ls_we`  in  1  1 = store, 0 = load
- `ls_len`  in  3  byte count: 1, 2 or 4
- `ls_addr`  in  ADDR_W  LS address
- `ls_wdata`  in  DATA_W  store data, low bytes used
- `ls_grant`  out  1  one-cycle pulse: LS request accepted
- `ls_done`  out  1  one-cycle pulse: access complete
- `ls_rdata`  out  DATA_W  load data, zero-extended
- `m_valid`  out  1  request to controller
- `m_we`  out  1  store
- `m_len`  out  3  byte count (fetch = 4)
- `m_addr`  out  ADDR_W  start address
- `m_wdata`  out  DATA_W  store data
- `m_ready`  in  1  controller accepts the request this cycle
- `m_done`  in  1  controller completion pulse
- `m_rdata`  in  DATA_W  controller read data, valid with `m_done`

## Operation
- States:
  - IDLE: arbitrate.
  - ISSUE: `m_valid`=1 until `m_ready`.
  - WAIT: await `m_done`.
  - DROP: await `m_done`, discard the result.
- Arbitration in IDLE, evaluated every cycle:
  - LS wins over IF unless `starve_cnt` = `STARVE_MAX` and `if_req`=1; IF then wins.
  - An LS store with `ls_addr` ≥ `IO_BASE` while `io_buffer_full`=1 is ineligible. IF is granted instead if requesting; otherwise stay IDLE.
- Grant cycle:
  - Pulse the winner's grant.
  - Latch the request into `m_*` registers and record the source.
  - Move to ISSUE.
- `starve_cnt`:
  - Increments on each LS grant while `if_req`=1, saturating at `STARVE_MAX`.
  - Clears on IF grant, or whenever `if_req`=0.
- ISSUE→WAIT on `m_ready`. WAIT→IDLE on `m_done`:
  - Pulse `if_done` or `ls_done` for the owner.
  - `if_inst` gets `m_rdata`.
  - `ls_rdata` gets `m_rdata` masked to `ls_len` bytes (stores: 0).
- `clr`:
  - In IDLE: no grant that cycle.
  - In ISSUE with owner IF or LS load: finish the handshake, then DROP instead of WAIT.
  - In WAIT with owner IF or LS load: go to DROP.
  - Owner LS store: unaffected (stores issue only post-commit).
  - DROP→IDLE on `m_done`, no done pulse.
- `ls_len`=3 is illegal and is treated as 4.

## Timing
- Reset values: all outputs 0; state IDLE; `starve_cnt` 0.
- Grant pulse in cycle N; `m_valid`=1 from N+1.
- Done pulse and data registered one cycle after `m_done`.
- Minimum request-to-done latency is 3 cycles plus controller time.
- Next arbitration happens in the cycle after the done pulse. This is one idle cycle on the memory port.
- `m_*` fields are stable while `m_valid`=1.
- `clr` coincident with `m_done` in WAIT: result dropped, no done pulse, next state IDLE.
- `rst` mid-transaction: state IDLE, pending result discarded. The controller is reset by the same `rst`.
- `rdy`=0: every register holds, including pulse outputs. Consumers gate with `rdy`.

## Structure
- Shared package: state encoding, `LEN_1/2/4`, source IDs `SRC_IF/SRC_LS`, `IO_BASE`.
- Sub-module `mem_arb_pick`: combinational winner selection from requests, `starve_cnt`, and IO-block condition. Everything else stays in the top level.

## Test plan
- `if_req` alone, addr 0x100; controller returns 0x00c00093 → `if_grant` at N, `m_len`=4, `if_done` with `if_inst`=0x00c00093, `starve_cnt` 0.
- `if_req` and `ls_req` (load, len 2, addr 0x200) together; `m_rdata`=0xdeadbeef → LS granted first, `ls_rdata`=0x0000beef, then IF granted.
- `if_req` held with 5 back-to-back LS requests, `STARVE_MAX`=4 → 4 LS grants, then IF, then the 5th LS.
- LS store to 0x30000 with `io_buffer_full`=1 and `if_req`=1 → IF granted, store held. Drop full → store granted with `m_we`=1.
- IF in WAIT, `clr` pulsed → `m_done` swallowed, no `if_done`. Repeat with a store → `ls_done` still pulses.
- `rst` asserted in ISSUE → next cycle all outputs 0, state IDLE, `rdy`=0 hold verified for 3 cycles.
